// File: rtl/md_sched_if.sv
// E-stage issue and HI/LO result bundle between the pipeline and the
// multiply/divide sequencer.
interface md_sched_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        d_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, src_a, src_b, d_is_md,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b, d_is_md,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide sequencer: latches the result at issue, holds a fixed busy
// window, then commits to HI/LO. Owns HI/LO and the D-stage stall request.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  md
);
    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        skip_q, skip_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_u, prod_s;
    logic        a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, sq_mag, sr_mag, q_s, r_s, q_u, r_u;

    // Signed product is the low 64 bits of the sign-extended product.
    assign prod_u = {32'd0, md.src_a} * {32'd0, md.src_b};
    assign prod_s = {{32{md.src_a[31]}}, md.src_a} * {{32{md.src_b[31]}}, md.src_b};

    // Signed divide via magnitudes, so 0x80000000 / -1 wraps to 0x80000000.
    assign a_neg  = md.src_a[31];
    assign b_neg  = md.src_b[31];
    assign b_zero = (md.src_b == 32'd0);
    assign a_mag  = a_neg ? (32'd0 - md.src_a) : md.src_a;
    assign b_mag  = b_neg ? (32'd0 - md.src_b) : md.src_b;
    assign sq_mag = b_zero ? 32'd0 : (a_mag / b_mag);
    assign sr_mag = b_zero ? 32'd0 : (a_mag % b_mag);
    assign q_s    = (a_neg ^ b_neg) ? (32'd0 - sq_mag) : sq_mag;
    assign r_s    = a_neg ? (32'd0 - sr_mag) : sr_mag;
    assign q_u    = b_zero ? 32'd0 : (md.src_a / md.src_b);
    assign r_u    = b_zero ? 32'd0 : (md.src_a % md.src_b);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        skip_d   = skip_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (md.start) begin
                    case (md.md_op)
                        3'd0: begin
                            {res_hi_d, res_lo_d} = prod_s;
                            cnt_d   = 4'(MULT_CYCLES - 1);
                            skip_d  = 1'b0;
                            state_d = RUN;
                        end
                        3'd1: begin
                            {res_hi_d, res_lo_d} = prod_u;
                            cnt_d   = 4'(MULT_CYCLES - 1);
                            skip_d  = 1'b0;
                            state_d = RUN;
                        end
                        3'd2: begin
                            res_hi_d = r_s;
                            res_lo_d = q_s;
                            cnt_d    = 4'(DIV_CYCLES - 1);
                            skip_d   = b_zero;
                            state_d  = RUN;
                        end
                        3'd3: begin
                            res_hi_d = r_u;
                            res_lo_d = q_u;
                            cnt_d    = 4'(DIV_CYCLES - 1);
                            skip_d   = b_zero;
                            state_d  = RUN;
                        end
                        3'd4:    hi_d = md.src_a;
                        3'd5:    lo_d = md.src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Starts are dropped here; the hazard unit should never issue one.
                if (cnt_q == 4'd0) begin
                    if (!skip_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            skip_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            skip_q   <= skip_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign md.busy     = (state_q == RUN);
    assign md.md_stall = md.d_is_md & (md.start | md.busy);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: latency windows, HI/LO results, stall, ignores.
module tb_md_sched;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    md_sched_if mif();

    md_sched dut (.clk(clk), .reset(reset), .md(mif));

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        mif.start = s;
        mif.md_op = op;
        mif.src_a = a;
        mif.src_b = b;
    endtask

    // Issue in the current cycle, then count busy cycles (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        drive(1'b1, op, a, b);
        tick();
        drive(1'b0, 3'd7, 32'd0, 32'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!mif.busy) break;
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        mif.d_is_md = 1'b0;
        drive(1'b1, 3'd4, 32'hDEADBEEF, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        drive(1'b0, 3'd7, 32'd0, 32'd0);
        #1;
        checks++;
        if (mif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", mif.busy); end
        checks++;
        if (mif.hi !== 32'd0 || mif.lo !== 32'd0) begin
            errors++; $display("FAIL reset_hilo got %h/%h want 0/0", mif.hi, mif.lo);
        end
        mif.d_is_md = 1'b1;
        #1;
        checks++;
        if (mif.md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %b want 0", mif.md_stall); end
        mif.start = 1'b1;
        #1;
        checks++;
        if (mif.md_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_start got %b want 1", mif.md_stall); end
        mif.start = 1'b0;
        mif.d_is_md = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        run_op(3'd0, 32'hFFFFFFFE, 32'd3, n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL mult_busy got %0d want 5", n); end
        checks++;
        if (mif.hi !== 32'hFFFFFFFF || mif.lo !== 32'hFFFFFFFA) begin
            errors++; $display("FAIL mult_res got %h/%h want ffffffff/fffffffa", mif.hi, mif.lo);
        end
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL multu_busy got %0d want 5", n); end
        checks++;
        if (mif.hi !== 32'hFFFFFFFE || mif.lo !== 32'h00000001) begin
            errors++; $display("FAIL multu_res got %h/%h want fffffffe/00000001", mif.hi, mif.lo);
        end
    endtask

    task automatic test_div();
        int n;
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL div_busy got %0d want 10", n); end
        checks++;
        if (mif.hi !== 32'hFFFFFFFF || mif.lo !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL div_res got %h/%h want ffffffff/fffffffd", mif.hi, mif.lo);
        end
        run_op(3'd3, 32'd7, 32'd0, n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL divu0_busy got %0d want 10", n); end
        checks++;
        if (mif.hi !== 32'hFFFFFFFF || mif.lo !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL divu0_res got %h/%h want ffffffff/fffffffd", mif.hi, mif.lo);
        end
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, n);
        checks++;
        if (mif.hi !== 32'd0 || mif.lo !== 32'h80000000) begin
            errors++; $display("FAIL div_ovf_res got %h/%h want 00000000/80000000", mif.hi, mif.lo);
        end
        run_op(3'd3, 32'd100, 32'd7, n);
        checks++;
        if (mif.hi !== 32'd2 || mif.lo !== 32'd14) begin
            errors++; $display("FAIL divu_res got %h/%h want 00000002/0000000e", mif.hi, mif.lo);
        end
    endtask

    task automatic test_stall_ignore();
        int n;
        mif.d_is_md = 1'b1;
        drive(1'b1, 3'd0, 32'd2, 32'd3);
        #1;
        checks++;
        if (mif.md_stall !== 1'b1) begin errors++; $display("FAIL stall_issue got %b want 1", mif.md_stall); end
        tick();
        drive(1'b0, 3'd7, 32'd0, 32'd0);
        n = 0;
        for (int c = 1; c <= 5; c++) begin
            if (mif.busy === 1'b1) n++;
            if (mif.md_stall !== 1'b1) begin
                errors++; $display("FAIL stall_busy cycle %0d got %b want 1", c, mif.md_stall);
            end
            if (c == 3) drive(1'b1, 3'd0, 32'd100, 32'd100);
            tick();
            drive(1'b0, 3'd7, 32'd0, 32'd0);
        end
        checks++;
        if (n !== 5) begin errors++; $display("FAIL stall_busy_count got %0d want 5", n); end
        checks++;
        if (mif.md_stall !== 1'b0 || mif.busy !== 1'b0) begin
            errors++; $display("FAIL stall_release got stall=%b busy=%b want 0/0", mif.md_stall, mif.busy);
        end
        checks++;
        if (mif.hi !== 32'd0 || mif.lo !== 32'd6) begin
            errors++; $display("FAIL ignore_res got %h/%h want 00000000/00000006", mif.hi, mif.lo);
        end
        mif.d_is_md = 1'b0;
    endtask

    task automatic test_mthi_mtlo();
        drive(1'b1, 3'd4, 32'h12345678, 32'd0);
        tick();
        checks++;
        if (mif.hi !== 32'h12345678 || mif.lo !== 32'd6 || mif.busy !== 1'b0) begin
            errors++; $display("FAIL mthi got hi=%h lo=%h busy=%b want 12345678/00000006/0", mif.hi, mif.lo, mif.busy);
        end
        drive(1'b1, 3'd5, 32'h9ABCDEF0, 32'd0);
        tick();
        checks++;
        if (mif.hi !== 32'h12345678 || mif.lo !== 32'h9ABCDEF0 || mif.busy !== 1'b0) begin
            errors++; $display("FAIL mtlo got hi=%h lo=%h busy=%b want 12345678/9abcdef0/0", mif.hi, mif.lo, mif.busy);
        end
        drive(1'b1, 3'd6, 32'h55555555, 32'h1);
        tick();
        drive(1'b1, 3'd7, 32'h66666666, 32'h1);
        tick();
        drive(1'b0, 3'd7, 32'd0, 32'd0);
        checks++;
        if (mif.hi !== 32'h12345678 || mif.lo !== 32'h9ABCDEF0 || mif.busy !== 1'b0) begin
            errors++; $display("FAIL noop got hi=%h lo=%h busy=%b want 12345678/9abcdef0/0", mif.hi, mif.lo, mif.busy);
        end
    endtask

    task automatic test_reset_run();
        int bad;
        drive(1'b1, 3'd2, 32'd100, 32'd7);
        tick();
        drive(1'b0, 3'd7, 32'd0, 32'd0);
        tick();
        tick();
        tick();
        checks++;
        if (mif.busy !== 1'b1) begin errors++; $display("FAIL rstrun_busy4 got %b want 1", mif.busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (mif.busy !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd0) begin
            errors++; $display("FAIL rstrun_after got busy=%b hi=%h lo=%h want 0/0/0", mif.busy, mif.hi, mif.lo);
        end
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (mif.busy !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rstrun_late got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        reset = 1'b0;
        mif.d_is_md = 1'b0;
        drive(1'b0, 3'd7, 32'd0, 32'd0);
        #2;
        test_reset();
        test_mult();
        test_div();
        test_stall_ignore();
        test_mthi_mtlo();
        test_reset_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
